// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and forwarding controller for the in-order pipeline. It keeps a
//   scoreboard of the instructions issued past ID. Slot 1 is EX and slot DEPTH
//   is writeback. From that scoreboard it produces:
//     - the load/multi-cycle-use stall,
//     - the branch squash,
//     - the EX forward selects,
//     - the ID/EX writeback bypass.
//   It also keeps saturating stall and flush performance counters.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs, id_rt              ID source registers
//   id_use_rs, id_use_rt      ID actually reads the source
//   id_dst, id_wr             ID destination register and write enable
//   id_load, id_mul           ID is a load / a multi-cycle op (load wins)
//   branch_taken              branch resolved in slot BR_SLOT is taken
//   stall                     hold PC and IF/ID, bubble into slot 1
//   flush                     squash IF/ID and the slots younger than BR_SLOT
//   fwd_rs, fwd_rt            EX operand select: 0 = ID/EX operand,
//                             k = result held in slot k+1
//   id_wb_rs, id_wb_rt        ID/EX operand captures the writeback value
//   stall_cnt, flush_cnt      saturating cycle counters

module hazard_ctrl #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_READY = 3,
  parameter int MUL_READY  = 3,
  parameter int BR_SLOT    = 2,
  parameter int CNT_W      = 16,
  localparam int FW        = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              id_mul,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush,
  output logic [FW-1:0]     fwd_rs,
  output logic [FW-1:0]     fwd_rt,
  output logic              id_wb_rs,
  output logic              id_wb_rt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Wide enough to hold a ready slot number up to DEPTH.
  localparam int RW = $clog2(DEPTH + 1);

  // Scoreboard, index 1 = EX ... DEPTH = writeback.
  logic              sb_vld    [1:DEPTH];
  logic              sb_wr     [1:DEPTH];
  logic [REG_AW-1:0] sb_dst    [1:DEPTH];
  logic [RW-1:0]     sb_rdy    [1:DEPTH];
  logic [REG_AW-1:0] sb_rs     [1:DEPTH];
  logic [REG_AW-1:0] sb_rt     [1:DEPTH];
  logic              sb_use_rs [1:DEPTH];
  logic              sb_use_rt [1:DEPTH];

  logic              stall_hit;
  logic              issue;

  // A source depends on a slot's result only when the slot really writes a
  // register. Register 0 is hard-wired, so it never creates a dependency.
  function automatic logic src_hit(input logic              vld,
                                   input logic              wr,
                                   input logic [REG_AW-1:0] dst,
                                   input logic              use_src,
                                   input logic [REG_AW-1:0] src);
    return vld && wr && use_src && (src != '0) && (dst == src);
  endfunction

  // Returns the first slot at which the result of the ID instruction can be
  // forwarded.
  function automatic logic [RW-1:0] ready_slot(input logic ld, input logic ml);
    if (ld)      return RW'(LOAD_READY);
    else if (ml) return RW'(MUL_READY);
    else         return RW'(2);
  endfunction

  // The counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---- ID stage: hazard detection against slots 1..DEPTH-1 ----
  // A producer in slot k reaches slot k+1 when the consumer enters EX. If that
  // slot is still short of the producer's ready slot, the consumer must wait.
  always_comb begin
    stall_hit = 1'b0;
    for (int k = 1; k < DEPTH; k++) begin
      if ((src_hit(sb_vld[k], sb_wr[k], sb_dst[k], id_use_rs, id_rs) ||
           src_hit(sb_vld[k], sb_wr[k], sb_dst[k], id_use_rt, id_rt)) &&
          ((k + 1) < 32'(sb_rdy[k])))
        stall_hit = 1'b1;
    end
  end

  // The branch squash wins over the stall. The instruction that would stall
  // is discarded anyway.
  always_comb begin
    flush = branch_taken && !reset;
    stall = id_valid && stall_hit && !flush && !reset;
    issue = id_valid && !stall && !flush;
  end

  // ---- ID stage: writeback bypass from slot DEPTH ----
  // The register-file write and the ID/EX capture happen on the same edge. The
  // read in ID would otherwise see the old register value.
  always_comb begin
    id_wb_rs = !reset && src_hit(sb_vld[DEPTH], sb_wr[DEPTH], sb_dst[DEPTH],
                                 id_use_rs, id_rs);
    id_wb_rt = !reset && src_hit(sb_vld[DEPTH], sb_wr[DEPTH], sb_dst[DEPTH],
                                 id_use_rt, id_rt);
  end

  // ---- EX stage: forward selects for the instruction in slot 1 ----
  // The scan runs from oldest to youngest, so the youngest (smallest k)
  // producer overwrites any older match.
  always_comb begin
    fwd_rs = '0;
    fwd_rt = '0;
    for (int k = DEPTH; k >= 2; k--) begin
      if (src_hit(sb_vld[k], sb_wr[k], sb_dst[k], sb_use_rs[1], sb_rs[1]))
        fwd_rs = FW'(k - 1);
      if (src_hit(sb_vld[k], sb_wr[k], sb_dst[k], sb_use_rt[1], sb_rt[1]))
        fwd_rt = FW'(k - 1);
    end
    if (!sb_vld[1] || reset) begin
      fwd_rs = '0;
      fwd_rt = '0;
    end
  end

  // ---- Scoreboard shift: valid bits and counters ----
  // On a flush, the instructions that were younger than the branch (old slots
  // 1..BR_SLOT-1) are killed as they shift. The branch and older slots move on
  // untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) sb_vld[k] <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      sb_vld[1] <= issue;
      for (int k = 2; k <= DEPTH; k++)
        sb_vld[k] <= sb_vld[k-1] && !(flush && ((k - 1) < BR_SLOT));
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  // ---- Scoreboard shift: payload ----
  // The payload fields are qualified by sb_vld, so they need no reset.
  always_ff @(posedge clock) begin
    sb_wr[1]     <= id_wr;
    sb_dst[1]    <= id_dst;
    sb_rdy[1]    <= ready_slot(id_load, id_mul);
    sb_rs[1]     <= id_rs;
    sb_rt[1]     <= id_rt;
    sb_use_rs[1] <= id_use_rs;
    sb_use_rt[1] <= id_use_rt;
    for (int k = 2; k <= DEPTH; k++) begin
      sb_wr[k]     <= sb_wr[k-1];
      sb_dst[k]    <= sb_dst[k-1];
      sb_rdy[k]    <= sb_rdy[k-1];
      sb_rs[k]     <= sb_rs[k-1];
      sb_rt[k]     <= sb_rt[k-1];
      sb_use_rs[k] <= sb_use_rs[k-1];
      sb_use_rt[k] <= sb_use_rt[k-1];
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline.
- Replaces the separate stall and forwarding logic with one block. The block keeps its own scoreboard of in-flight instructions, DEPTH slots past issue.
- Generates forward selects, load/multi-cycle-use stalls and branch squash.
- Adds saturating stall/flush performance counters.

Parameters:
- DEPTH, 3: scoreboard slots after ID. Slot 1 = EX, slot DEPTH = writeback stage. Legal range 2..8.
- REG_AW, 5: register index width. Register 0 is never a hazard.
- LOAD_READY, 3: first slot at which a load result can be forwarded. Range 2..DEPTH.
- MUL_READY, 3: first slot at which a multi-cycle op result can be forwarded. Range 2..DEPTH.
- BR_SLOT, 2: slot in which branch_taken is resolved. Range 1..DEPTH.
- CNT_W, 16: performance counter width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_AW  ID source 1.
- id_rt  in  REG_AW  ID source 2.
- id_use_rs  in  1  ID reads rs.
- id_use_rt  in  1  ID reads rt.
- id_dst  in  REG_AW  ID destination after rd/rt select.
- id_wr  in  1  ID writes a register.
- id_load  in  1  ID is a load.
- id_mul  in  1  ID is a multi-cycle op.
- branch_taken  in  1  branch in slot BR_SLOT taken this cycle.
- stall  out  1  hold PC and IF/ID; insert bubble into slot 1.
- flush  out  1  squash IF/ID and all slots younger than BR_SLOT.
- fwd_rs  out  clog2(DEPTH)  EX source 1 select. 0 = ID/EX operand; k = result of slot k+1.
- fwd_rt  out  clog2(DEPTH)  same, for source 2.
- id_wb_rs  out  1  ID/EX rs operand takes writeback data this edge.
- id_wb_rt  out  1  same, for rt.
- stall_cnt  out  CNT_W  cycles with stall asserted, saturating.
- flush_cnt  out  CNT_W  cycles with flush asserted, saturating.

Behaviour:
- Slot contents: valid, dst, wr, rdy, rs, rt, use_rs, use_rt. rdy = LOAD_READY if load, else MUL_READY if mul, else 2. If id_load and id_mul are both set, load wins.
- Every edge (absent reset), slots k+1 <= k for k = 1..DEPTH-1; slot DEPTH retires.
- Slot 1 loads the ID instruction when id_valid & !stall & !flush. Otherwise slot 1 loads a bubble (valid=0).
- Source match, operand src of ID against slot k: slot valid, wr set, use bit set, src != 0, dst == src.
- stall (combinational): some ID source matches a slot k in 1..DEPTH-1 with k+1 < rdy(k).
  - Only id_valid instructions can stall. The condition re-evaluates each cycle.
  - Result: a load in slot 1 with LOAD_READY=3 gives exactly 1 stall cycle.
- flush (combinational) = branch_taken. Flush overrides stall: stall is forced to 0 while flush is 1.
- At a flush edge, slots 1..BR_SLOT-1 become invalid after the shift. Slot BR_SLOT and older are untouched. Slot 1 loads a bubble.
- fwd_rs / fwd_rt describe the instruction in slot 1.
  - Select the smallest k in 2..DEPTH where slot k matches slot 1's source; output k-1.
  - Output 0 when there is no match, slot 1 is invalid, or the source is 0.
  - If the matched slot has k < rdy, that is an invariant violation; the bench flags it.
- id_wb_rs / id_wb_rt = ID source matches slot DEPTH. These bypass the writeback value into ID/EX, since the write and the ID/EX capture occur at the same edge.
- Counters: +1 per cycle of stall or flush respectively. They hold at all-ones.
- Reset:
  - All slots invalid, counters 0.
  - Outputs read 0 during and after reset until valid traffic arrives.
  - Reset mid-operation discards all in-flight state in one cycle.
  - branch_taken is ignored while reset is high.
- Width rule: select fields are zero-extended; unused codes (>= DEPTH) are never driven.

Test Plan:
- Defaults, load r8 then add r9,r8,r1 back-to-back -> stall=1 for 1 cycle. Next cycle: add in slot 1, fwd_rs=2 (slot 3). stall_cnt=1.
- add r3,r1,r2 then sub r4,r3,r3 -> no stall. sub in EX gets fwd_rs=1, fwd_rt=1. With one unrelated instruction between: fwd=2.
- Producer in slot DEPTH while consumer in ID -> id_wb_rs=1. Destination r0 in any slot -> all forwards 0, no stall.
- DEPTH=5, MUL_READY=5, mul r5 then use of r5 -> 3 stall cycles, then fwd=4.
- branch_taken with BR_SLOT=2, slot 1 valid, stall condition also true -> flush=1, stall=0. Slot 2 invalid next cycle, old slot 2 in slot 3. flush_cnt=1.
- Assert reset mid-stall for 1 cycle -> stall=0 next cycle, slots empty, counters 0. Then force CNT_W=4 and 20 stall cycles -> stall_cnt saturates at 15.
